// File: rtl/regfile_bypass.sv
// Register file with NUM_RD combinational read ports and EX/MEM/WB bypassing into ID.
// Latency: reads are zero-cycle (combinational); the WB write commits on the rising edge.
// Backpressure: stall_req flags a load-use hazard; ID holds and this block re-evaluates each cycle.
module regfile_bypass #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     ex_we,
   input  logic [ADDR_W-1:0]        ex_waddr,
   input  logic [DATA_W-1:0]        ex_wdata,
   input  logic                     ex_is_load,
   input  logic                     mem_we,
   input  logic [ADDR_W-1:0]        mem_waddr,
   input  logic [DATA_W-1:0]        mem_wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic                     stall_req,
   output logic [15:0]              wr_count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [15:0]       wr_count_q;
   logic [15:0]       wr_count_d;
   logic              commit;
   logic [NUM_RD-1:0] hazard;

   // A WB write commits unless it targets the hard-wired zero register.
   always_comb begin
      commit = we && !((ZERO_REG != 0) && (waddr == '0));
   end

   // Next write count, wrapping naturally at 16 bits.
   always_comb begin
      wr_count_d = wr_count_q;
      if (commit) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   // Array storage; reset clears every entry so a reset mid-write leaves the entry at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Committed write counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
      end
   end

   assign wr_count = wr_count_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;
      logic              hz;

      assign ra = raddr[p*ADDR_W +: ADDR_W];

      // Per-port read mux: youngest producer wins, a pending load returns 0 and raises a hazard.
      always_comb begin
         rd_val = '0;
         hz     = 1'b0;
         if (rst || !re[p]) begin
            rd_val = '0;
         end else if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_val = '0;
         end else if (ex_we && (ex_waddr == ra)) begin
            if (ex_is_load) begin
               hz = 1'b1;
            end else begin
               rd_val = ex_wdata;
            end
         end else if (mem_we && (mem_waddr == ra)) begin
            rd_val = mem_wdata;
         end else if (we && (waddr == ra)) begin
            rd_val = wdata;
         end else begin
            rd_val = mem_q[ra];
         end
      end

      assign rdata[p*DATA_W +: DATA_W] = rd_val;
      assign hazard[p]                 = hz;
   end

   assign stall_req = |hazard;

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: table vectors plus hand sequences, checked through an expectation queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A second instance (NUM_RD=4, ZERO_REG=0) covers the wide, non-zero-register build.
module tb_regfile_bypass;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, ex_we, ex_is_load, mem_we;
   logic [4:0]  waddr, ex_waddr, mem_waddr;
   logic [31:0] wdata, ex_wdata, mem_wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        stall_req;
   logic [15:0] wr_count;

   logic [3:0]   re4;
   logic [19:0]  raddr4;
   logic [127:0] rdata4;
   logic         stall4;
   logic [15:0]  wr_count4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .re(re), .raddr(raddr), .rdata(rdata), .stall_req(stall_req), .wr_count(wr_count)
   );

   regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) u_dut4 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .re(re4), .raddr(raddr4), .rdata(rdata4), .stall_req(stall4), .wr_count(wr_count4)
   );

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ex_we;
      logic [4:0]  ex_waddr;
      logic [31:0] ex_wdata;
      logic        ex_is_load;
      logic        mem_we;
      logic [4:0]  mem_waddr;
      logic [31:0] mem_wdata;
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic        e_stall;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct {
      int          tag;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[13];

   task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, tag, act, want);
      end
   endtask

   task automatic set_idle();
      we = 1'b0; waddr = '0; wdata = '0;
      ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_is_load = 1'b0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      re = '0; raddr = '0;
   endtask

   // Apply one vector's inputs and queue the outputs it must produce.
   task automatic drive(input int tag, input vec_t v);
      exp_t e;
      we = v.we; waddr = v.waddr; wdata = v.wdata;
      ex_we = v.ex_we; ex_waddr = v.ex_waddr; ex_wdata = v.ex_wdata; ex_is_load = v.ex_is_load;
      mem_we = v.mem_we; mem_waddr = v.mem_waddr; mem_wdata = v.mem_wdata;
      re = v.re; raddr = {v.ra1, v.ra0};
      e.tag = tag; e.rd0 = v.e_rd0; e.rd1 = v.e_rd1; e.stall = v.e_stall; e.cnt = v.e_cnt;
      exp_q.push_back(e);
   endtask

   task automatic compare_pop();
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=0 want=1");
      end else begin
         checks--;
         e = exp_q.pop_front();
         chk("rdata0", e.tag, rdata[31:0], e.rd0);
         chk("rdata1", e.tag, rdata[63:32], e.rd1);
         chk("stall_req", e.tag, {31'd0, stall_req}, {31'd0, e.stall});
         chk("wr_count", e.tag, {16'd0, wr_count}, {16'd0, e.cnt});
      end
   endtask

   task automatic run_vec(input int tag, input vec_t v);
      @(posedge clk);
      #1;
      drive(tag, v);
      @(negedge clk);
      compare_pop();
   endtask

   function automatic vec_t mk_rw(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                                  input logic [31:0] e0, input logic [31:0] e1,
                                  input logic es, input logic [15:0] ec);
      vec_t v;
      v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
            2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 16'd0};
      v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.ra0 = a0; v.ra1 = a1;
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_stall = es; v.e_cnt = ec;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      re4 = '0; raddr4 = '0;

      // Table: rows run back to back, so wr_count follows the commits of earlier rows.
      tbl[0]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h77, 1'b0, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 16'd1};
      tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 16'd1};
      tbl[2]  = '{1'b1, 5'd3, 32'hC, 1'b1, 5'd3, 32'hA, 1'b0, 1'b1, 5'd3, 32'hB,
                  2'b11, 5'd3, 5'd3, 32'hA, 32'hA, 1'b0, 16'd1};
      tbl[3]  = '{1'b1, 5'd3, 32'hC, 1'b0, 5'd3, 32'hA, 1'b0, 1'b1, 5'd3, 32'hB,
                  2'b11, 5'd3, 5'd3, 32'hB, 32'hB, 1'b0, 16'd2};
      tbl[4]  = '{1'b1, 5'd3, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd3, 5'd3, 32'hC, 32'hC, 1'b0, 16'd3};
      tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd3, 5'd3, 32'hC, 32'hC, 1'b0, 16'd4};
      tbl[6]  = '{1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                  2'b01, 5'd2, 5'd2, 32'h22, 32'h0, 1'b0, 16'd4};
      tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd2, 5'd7, 32'h22, 32'h0, 1'b1, 16'd5};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h55,
                  2'b11, 5'd2, 5'd7, 32'h22, 32'h55, 1'b0, 16'd5};
      tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'h0,
                  2'b01, 5'd2, 5'd7, 32'h22, 32'h0, 1'b0, 16'd5};
      tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'h13, 32'h99, 1'b0, 1'b1, 5'h17, 32'h55,
                  2'b11, 5'd3, 5'd7, 32'hC, 32'h0, 1'b0, 16'd5};
      tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd6, 32'h66,
                  2'b11, 5'd6, 5'd4, 32'h66, 32'h44, 1'b0, 16'd5};
      tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
                  2'b11, 5'd0, 5'd2, 32'h0, 32'h22, 1'b0, 16'd5};

      // Reset holds everything at zero even with a write, bypass and load hazard presented.
      rst = 1'b1;
      v = tbl[7];
      v.we = 1'b1; v.waddr = 5'd5; v.wdata = 32'h5555; v.ra0 = 5'd5;
      v.e_rd0 = 32'h0; v.e_rd1 = 32'h0; v.e_stall = 1'b0; v.e_cnt = 16'd0;
      drive(0, v);
      #3;
      compare_pop();
      set_idle();
      @(negedge clk);
      rst = 1'b0;

      // Write r5, then read it back from the array with nothing bypassing.
      run_vec(1, mk_rw(1'b1, 5'd5, 32'h0000_1234, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 16'd0));
      run_vec(2, mk_rw(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 32'h0000_1234, 32'h0, 1'b0, 16'd1));

      for (int i = 0; i < 13; i++) begin
         run_vec(10 + i, tbl[i]);
      end

      // Drive wr_count from 5 up to 0xFFFF with back-to-back writes of r1.
      for (int n = 0; n < 65530; n++) begin
         @(posedge clk);
         #1;
         set_idle();
         we = 1'b1; waddr = 5'd1; wdata = n;
      end
      run_vec(30, mk_rw(1'b1, 5'd1, 32'h1111, 2'b01, 5'd1, 5'd0, 32'h1111, 32'h0, 1'b0, 16'hFFFF));
      run_vec(31, mk_rw(1'b1, 5'd1, 32'h2222, 2'b01, 5'd1, 5'd0, 32'h2222, 32'h0, 1'b0, 16'h0000));

      // Mid-cycle reset during a write of r1 while a load hazard is pending on port 1.
      v = mk_rw(1'b1, 5'd1, 32'hBEEF, 2'b11, 5'd1, 5'd9, 32'hBEEF, 32'h0, 1'b1, 16'd1);
      v.ex_we = 1'b1; v.ex_waddr = 5'd9; v.ex_is_load = 1'b1;
      run_vec(32, v);
      #2;
      rst = 1'b1;
      v.e_rd0 = 32'h0; v.e_stall = 1'b0; v.e_cnt = 16'd0;
      drive(33, v);
      #1;
      compare_pop();
      @(posedge clk);
      #1;
      set_idle();
      @(negedge clk);
      rst = 1'b0;
      run_vec(34, mk_rw(1'b0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd3, 32'h0, 32'h0, 1'b0, 16'd0));

      // Wide build without a zero register: r0 is ordinary and re masks ports 0 and 2.
      @(posedge clk);
      #1;
      set_idle();
      we = 1'b1; waddr = 5'd0; wdata = 32'h99;
      @(posedge clk);
      #1;
      set_idle();
      re4 = 4'b1010; raddr4 = '0; re = 2'b01;
      @(negedge clk);
      chk("p4_rdata0", 40, rdata4[31:0], 32'h0);
      chk("p4_rdata1", 40, rdata4[63:32], 32'h99);
      chk("p4_rdata2", 40, rdata4[95:64], 32'h0);
      chk("p4_rdata3", 40, rdata4[127:96], 32'h99);
      chk("p4_stall", 40, {31'd0, stall4}, 32'd0);
      chk("p4_wr_count", 40, {16'd0, wr_count4}, 32'd1);
      chk("zr_wr_count", 40, {16'd0, wr_count}, 32'd0);
      chk("zr_rdata0", 40, rdata[31:0], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
